vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arb_pkg.sv | 14 +
 rtl/vram_rd_pipe.sv | 63 ++++++
 rtl/vram_arbiter.sv | 136 +++++++++++++
 tb/tb_vram_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_arb_pkg.sv
// rtl/vram_arb_pkg.sv - shared defaults and source tags for the VRAM arbiter.
package vram_arb_pkg;

   localparam int DEF_ADDR_W     = 16;
   localparam int DEF_DATA_W     = 8;
   localparam int DEF_STARVE_LIM = 64;

   typedef enum logic [1:0] {
      SRC_NONE = 2'd0,
      SRC_VGA  = 2'd1,
      SRC_CPU  = 2'd2
   } src_e;

endpackage

// File: rtl/vram_rd_pipe.sv
// rtl/vram_rd_pipe.sv - two-stage source-tag pipeline steering RAM read data back to VGA or CPU.
module vram_rd_pipe
   import vram_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  src_e              issue_src,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              vga_valid,
   output logic [DATA_W-1:0] vga_data,
   output logic              cpu_rvalid,
   output logic [DATA_W-1:0] cpu_rdata
);

   src_e              tag_s1_q, tag_s1_d;
   src_e              tag_s2_q, tag_s2_d;
   logic              vga_valid_q, vga_valid_d;
   logic [DATA_W-1:0] vga_data_q, vga_data_d;
   logic              cpu_rvalid_q, cpu_rvalid_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;

   // RAM data is only valid during the cycle after stage 2, so it is captured on leaving stage 2.
   always_comb begin
      tag_s1_d     = issue_src;
      tag_s2_d     = tag_s1_q;
      vga_valid_d  = (tag_s2_q == SRC_VGA);
      cpu_rvalid_d = (tag_s2_q == SRC_CPU);
      vga_data_d   = vga_data_q;
      cpu_rdata_d  = cpu_rdata_q;
      if (vga_valid_d) begin
         vga_data_d = mem_rdata;
      end
      if (cpu_rvalid_d) begin
         cpu_rdata_d = mem_rdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tag_s1_q     <= SRC_NONE;
         tag_s2_q     <= SRC_NONE;
         vga_valid_q  <= 1'b0;
         vga_data_q   <= '0;
         cpu_rvalid_q <= 1'b0;
         cpu_rdata_q  <= '0;
      end else begin
         tag_s1_q     <= tag_s1_d;
         tag_s2_q     <= tag_s2_d;
         vga_valid_q  <= vga_valid_d;
         vga_data_q   <= vga_data_d;
         cpu_rvalid_q <= cpu_rvalid_d;
         cpu_rdata_q  <= cpu_rdata_d;
      end
   end

   assign vga_valid  = vga_valid_q;
   assign vga_data   = vga_data_q;
   assign cpu_rvalid = cpu_rvalid_q;
   assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - single-port VRAM arbiter: absolute VGA priority, one-entry CPU slot.
// Define VRAM_CPU_READ_EN to enable CPU loads; without it loads are dropped at accept.
module vram_arbiter
   import vram_arb_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DATA_W     = DEF_DATA_W,
   parameter int STARVE_LIM = DEF_STARVE_LIM
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              vga_req,
   input  logic [ADDR_W-1:0] vga_addr,
   output logic [DATA_W-1:0] vga_data,
   output logic              vga_valid,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic              cpu_ready,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_rvalid,
   output logic              cpu_starved,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int WAIT_W = $clog2(STARVE_LIM + 1);

   logic              slot_full_q, slot_full_d;
   logic              slot_we_q, slot_we_d;
   logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
   logic [DATA_W-1:0] slot_wdata_q, slot_wdata_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              starved_q, starved_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   src_e              issue_src;
   logic              accept;

`ifdef VRAM_CPU_READ_EN
   assign accept = cpu_req & ~slot_full_q;
`else
   assign accept = cpu_req & ~slot_full_q & cpu_we;
`endif

   always_comb begin
      mem_addr_d   = mem_addr_q;
      mem_wdata_d  = mem_wdata_q;
      mem_we_d     = 1'b0;
      issue_src    = SRC_NONE;
      slot_full_d  = slot_full_q;
      slot_we_d    = slot_we_q;
      slot_addr_d  = slot_addr_q;
      slot_wdata_d = slot_wdata_q;
      wait_d       = wait_q;
      starved_d    = starved_q;

      if (vga_req) begin
         mem_addr_d = vga_addr;
         issue_src  = SRC_VGA;
         if (slot_full_q && (wait_q != WAIT_W'(STARVE_LIM))) begin
            wait_d = wait_q + 1'b1;
         end
      end else if (slot_full_q) begin
         mem_addr_d  = slot_addr_q;
         mem_we_d    = slot_we_q;
         slot_full_d = 1'b0;
         wait_d      = '0;
         if (slot_we_q) begin
            mem_wdata_d = slot_wdata_q;
         end else begin
            issue_src = SRC_CPU;
         end
      end

      if (wait_d == WAIT_W'(STARVE_LIM)) begin
         starved_d = 1'b1;
      end

      // accept looks at the pre-edge slot state, so a slot drained this edge is refilled next edge at the earliest.
      if (accept) begin
         slot_full_d  = 1'b1;
         slot_we_d    = cpu_we;
         slot_addr_d  = cpu_addr;
         slot_wdata_d = cpu_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         slot_full_q  <= 1'b0;
         slot_we_q    <= 1'b0;
         slot_addr_q  <= '0;
         slot_wdata_q <= '0;
         wait_q       <= '0;
         starved_q    <= 1'b0;
         mem_addr_q   <= '0;
         mem_we_q     <= 1'b0;
         mem_wdata_q  <= '0;
      end else begin
         slot_full_q  <= slot_full_d;
         slot_we_q    <= slot_we_d;
         slot_addr_q  <= slot_addr_d;
         slot_wdata_q <= slot_wdata_d;
         wait_q       <= wait_d;
         starved_q    <= starved_d;
         mem_addr_q   <= mem_addr_d;
         mem_we_q     <= mem_we_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign cpu_ready   = ~slot_full_q;
   assign cpu_starved = starved_q;
   assign mem_addr    = mem_addr_q;
   assign mem_we      = mem_we_q;
   assign mem_wdata   = mem_wdata_q;

   vram_rd_pipe #(
      .DATA_W (DATA_W)
   ) u_rd_pipe (
      .clk        (clk),
      .rst        (rst),
      .issue_src  (issue_src),
      .mem_rdata  (mem_rdata),
      .vga_valid  (vga_valid),
      .vga_data   (vga_data),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata)
   );

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - directed and randomized bench for vram_arbiter against a queue-based model.
// Honours VRAM_CPU_READ_EN the same way as the design.
module tb_vram_arbiter;

   localparam int ADDR_W     = 16;
   localparam int DATA_W     = 8;
   localparam int STARVE_LIM = 64;
`ifdef VRAM_CPU_READ_EN
   localparam bit READ_EN = 1'b1;
`else
   localparam bit READ_EN = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              vga_req = 1'b0;
   logic [ADDR_W-1:0] vga_addr = '0;
   logic [DATA_W-1:0] vga_data;
   logic              vga_valid;
   logic              cpu_req = 1'b0;
   logic              cpu_we = 1'b0;
   logic [ADDR_W-1:0] cpu_addr = '0;
   logic [DATA_W-1:0] cpu_wdata = '0;
   logic              cpu_ready;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_rvalid;
   logic              cpu_starved;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_we;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata = '0;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   vram_arbiter #(
      .ADDR_W     (ADDR_W),
      .DATA_W     (DATA_W),
      .STARVE_LIM (STARVE_LIM)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .vga_req     (vga_req),
      .vga_addr    (vga_addr),
      .vga_data    (vga_data),
      .vga_valid   (vga_valid),
      .cpu_req     (cpu_req),
      .cpu_we      (cpu_we),
      .cpu_addr    (cpu_addr),
      .cpu_wdata   (cpu_wdata),
      .cpu_ready   (cpu_ready),
      .cpu_rdata   (cpu_rdata),
      .cpu_rvalid  (cpu_rvalid),
      .cpu_starved (cpu_starved),
      .mem_addr    (mem_addr),
      .mem_we      (mem_we),
      .mem_wdata   (mem_wdata),
      .mem_rdata   (mem_rdata)
   );

   function automatic logic [7:0] ram_init(input int a);
      if (a == 'h10) return 8'hA5;
      if (a == 'h300) return 8'h77;
      return 8'(a) ^ 8'h5A;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Synchronous single-port RAM: read data one cycle after the command edge, read-before-write.
   logic [7:0] ram [0:65535];
   initial begin
      for (int i = 0; i < 65536; i++) ram[i] = ram_init(i);
      forever begin
         @(posedge clk);
         mem_rdata <= ram[mem_addr];
         if (mem_we) ram[mem_addr] <= mem_wdata;
      end
   end

   // Reference model: what the RAM should see and which read returns are due on which cycle.
   typedef struct {
      int         due;
      bit         is_vga;
      logic [7:0] data;
   } ret_t;

   logic [7:0]  mmem [0:65535];
   ret_t        rq[$];
   int          cyc = 0;
   bit          m_slot_v;
   bit          m_slot_we;
   logic [15:0] m_slot_addr;
   logic [7:0]  m_slot_data;
   int          m_wait;
   bit          m_starved;
   logic [15:0] m_addr;
   logic        m_we;
   logic [7:0]  m_wdata;

   initial begin
      bit         ready_pre;
      bit         exp_vv, exp_cv;
      logic [7:0] exp_d;
      for (int i = 0; i < 65536; i++) mmem[i] = ram_init(i);
      forever begin
         @(posedge clk);
         cyc++;
         if (!rst) begin
            m_slot_v = 0; m_wait = 0; m_starved = 0;
            m_addr = '0; m_we = 1'b0; m_wdata = '0;
            rq.delete();
         end else begin
            ready_pre = !m_slot_v;
            m_we = 1'b0;
            if (vga_req) begin
               m_addr = vga_addr;
               rq.push_back('{due: cyc + 2, is_vga: 1'b1, data: mmem[vga_addr]});
               if (m_slot_v) begin
                  if (m_wait < STARVE_LIM) m_wait++;
                  if (m_wait == STARVE_LIM) m_starved = 1;
               end
            end else if (m_slot_v) begin
               m_addr = m_slot_addr;
               m_we   = m_slot_we;
               if (m_slot_we) begin
                  m_wdata = m_slot_data;
                  mmem[m_slot_addr] = m_slot_data;
               end else begin
                  rq.push_back('{due: cyc + 2, is_vga: 1'b0, data: mmem[m_slot_addr]});
               end
               m_slot_v = 0;
               m_wait   = 0;
            end
            if (cpu_req && ready_pre && (cpu_we || READ_EN)) begin
               m_slot_v    = 1;
               m_slot_we   = cpu_we;
               m_slot_addr = cpu_addr;
               m_slot_data = cpu_wdata;
            end
         end
         #1;
         exp_vv = 0; exp_cv = 0; exp_d = '0;
         if (rq.size() > 0 && rq[0].due == cyc) begin
            exp_vv = rq[0].is_vga;
            exp_cv = !rq[0].is_vga;
            exp_d  = rq[0].data;
            void'(rq.pop_front());
         end
         check("mem_we", 32'(mem_we), 32'(m_we));
         check("mem_addr", 32'(mem_addr), 32'(m_addr));
         if (m_we || !rst) check("mem_wdata", 32'(mem_wdata), 32'(m_wdata));
         check("cpu_ready", 32'(cpu_ready), 32'(!m_slot_v));
         check("cpu_starved", 32'(cpu_starved), 32'(m_starved));
         check("vga_valid", 32'(vga_valid), 32'(exp_vv));
         check("cpu_rvalid", 32'(cpu_rvalid), 32'(exp_cv));
         if (exp_vv) check("vga_data", 32'(vga_data), 32'(exp_d));
         if (exp_cv) check("cpu_rdata", 32'(cpu_rdata), 32'(exp_d));
         if (!rst) check("vga_data_rst", 32'(vga_data), 32'h0);
         if (!rst || !READ_EN) check("cpu_rdata_zero", 32'(cpu_rdata), 32'h0);
      end
   end

   int pct_tab [6] = '{20, 50, 90, 0, 100, 60};

   initial begin
      bit acc;
      repeat (3) tick();
      check("rst_cpu_ready", 32'(cpu_ready), 32'h1);
      check("rst_mem_addr", 32'(mem_addr), 32'h0);
      check("rst_vga_valid", 32'(vga_valid), 32'h0);
      rst = 1'b1;
      tick();

      // VGA read of 0x0010 returns 0xA5 two cycles after the command edge.
      vga_req = 1'b1; vga_addr = 16'h0010;
      tick();
      check("d36_mem_addr", 32'(mem_addr), 32'h0010);
      check("d36_mem_we", 32'(mem_we), 32'h0);
      vga_req = 1'b0;
      tick();
      check("d36_early", 32'(vga_valid), 32'h0);
      tick();
      check("d36_valid", 32'(vga_valid), 32'h1);
      check("d36_data", 32'(vga_data), 32'hA5);
      tick();
      check("d36_pulse", 32'(vga_valid), 32'h0);

      // CPU store issues one cycle after accept.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'h3C;
      tick();
      check("d37_busy", 32'(cpu_ready), 32'h0);
      cpu_req = 1'b0;
      tick();
      check("d37_we", 32'(mem_we), 32'h1);
      check("d37_addr", 32'(mem_addr), 32'h0200);
      check("d37_wdata", 32'(mem_wdata), 32'h3C);
      check("d37_ready", 32'(cpu_ready), 32'h1);
      tick();
      check("d37_once", 32'(mem_we), 32'h0);

      // Store waits behind three VGA reads.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0201; cpu_wdata = 8'hC3;
      vga_req = 1'b1; vga_addr = 16'h0020;
      tick();
      cpu_req = 1'b0; vga_addr = 16'h0021;
      tick();
      check("d38_blocked", 32'(mem_we), 32'h0);
      vga_addr = 16'h0022;
      tick();
      check("d38_v0", 32'(vga_data), 32'h7A);
      vga_req = 1'b0;
      tick();
      check("d38_we", 32'(mem_we), 32'h1);
      check("d38_addr", 32'(mem_addr), 32'h0201);
      check("d38_v1", 32'(vga_data), 32'h7B);
      tick();
      check("d38_v2", 32'(vga_data), 32'h78);
      check("d38_v2_valid", 32'(vga_valid), 32'h1);

      // 64 blocked cycles set the sticky starvation flag.
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0202; cpu_wdata = 8'h99;
      vga_req = 1'b1; vga_addr = 16'h0040;
      tick();
      cpu_req = 1'b0;
      for (int i = 1; i < 64; i++) begin
         vga_addr = 16'(16'h0040 + i);
         tick();
      end
      check("d39_before", 32'(cpu_starved), 32'h0);
      tick();
      check("d39_set", 32'(cpu_starved), 32'h1);
      vga_req = 1'b0;
      tick();
      check("d39_issue", 32'(mem_we), 32'h1);
      tick(); tick();
      check("d39_sticky", 32'(cpu_starved), 32'h1);

      // CPU load of 0x0300.
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
`ifdef VRAM_CPU_READ_EN
      tick();
      cpu_req = 1'b0;
      tick();
      check("d40_addr", 32'(mem_addr), 32'h0300);
      tick();
      check("d40_early", 32'(cpu_rvalid), 32'h0);
      tick();
      check("d40_valid", 32'(cpu_rvalid), 32'h1);
      check("d40_data", 32'(cpu_rdata), 32'h77);
      tick();
      check("d40_pulse", 32'(cpu_rvalid), 32'h0);
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
      tick();
      cpu_req = 1'b0;
      tick();
`else
      tick();
      check("d40_ready", 32'(cpu_ready), 32'h1);
      cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("d40_no_cmd", 32'(mem_addr), 32'h0202);
         check("d40_no_rvalid", 32'(cpu_rvalid), 32'h0);
      end
      vga_req = 1'b1; vga_addr = 16'h0010;
      tick();
      vga_req = 1'b0;
`endif

      // Asynchronous reset with a read in flight.
      @(posedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("d41_ready", 32'(cpu_ready), 32'h1);
      check("d41_we", 32'(mem_we), 32'h0);
      check("d41_addr", 32'(mem_addr), 32'h0);
      check("d41_wdata", 32'(mem_wdata), 32'h0);
      check("d41_vvalid", 32'(vga_valid), 32'h0);
      check("d41_cvalid", 32'(cpu_rvalid), 32'h0);
      check("d41_starved", 32'(cpu_starved), 32'h0);
      check("d41_vdata", 32'(vga_data), 32'h0);
      check("d41_cdata", 32'(cpu_rdata), 32'h0);
      tick(); tick();
      rst = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("d41_quiet", 32'({vga_valid, cpu_rvalid}), 32'h0);
      end

      // Randomized traffic; the CPU side holds each request until accepted.
      acc = 0;
      for (int c = 0; c < 3000; c++) begin
         if (c == 1500) begin
            rst = 1'b0;
            cpu_req = 1'b0;
            vga_req = 1'b0;
            tick(); tick();
            rst = 1'b1;
            acc = 0;
         end
         if (!cpu_req || acc) begin
            cpu_req = ($urandom_range(0, 99) < 45);
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = 16'($urandom_range(0, 31));
            cpu_wdata = 8'($urandom_range(0, 255));
         end
         vga_req = ($urandom_range(0, 99) < pct_tab[(c / 500) % 6]);
         vga_addr = 16'($urandom_range(0, 31));
         acc = cpu_req && cpu_ready;
         tick();
      end
      cpu_req = 1'b0;
      vga_req = 1'b0;
      repeat (4) tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
